// File: rtl/design_switch_sequencer.sv
// design_switch_sequencer: controlled handover of the active student design.
// Drains the Wishbone bus, isolates shared outputs and reset-pulses the new design.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   design_select     - requested design (0 or > NUM_PROJECTS means none)
//   wbs_cyc_i         - Wishbone cycle in progress
//   active_select     - design currently routed by the output mux (0 = none)
//   designs_cs        - active-low chip selects, [NUM_PROJECTS:1]
//   designs_n_rst     - active-low design resets, [NUM_PROJECTS:1]
//   isolate           - force shared outputs to their safe values
//   switch_busy       - handover in progress
//   drain_timeout     - one-cycle pulse when the bus drain wait expired

module design_switch_sequencer #(
    parameter int NUM_PROJECTS  = 13,
    parameter int RST_CYCLES    = 8,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            design_select,
    input  logic                  wbs_cyc_i,
    output logic [3:0]            active_select,
    output logic [NUM_PROJECTS:1] designs_cs,
    output logic [NUM_PROJECTS:1] designs_n_rst,
    output logic                  isolate,
    output logic                  switch_busy,
    output logic                  drain_timeout
);

    localparam int CNT_MAX =
        (RST_CYCLES > DRAIN_TIMEOUT) ? RST_CYCLES : DRAIN_TIMEOUT;
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [4:0]    NP         = 5'(NUM_PROJECTS);

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        ISOLATE,
        RESET_HOLD,
        RELEASE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [3:0]            req_q;
    logic [3:0]            req_d;
    logic [3:0]            active_q;
    logic [3:0]            active_d;
    logic [3:0]            target_q;
    logic [3:0]            target_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [NUM_PROJECTS:1] cs_q;
    logic [NUM_PROJECTS:1] cs_d;
    logic [NUM_PROJECTS:1] nrst_q;
    logic [NUM_PROJECTS:1] nrst_d;
    logic                  iso_q;
    logic                  iso_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  dto_q;
    logic                  dto_d;

    // slot that owns cs/n_rst in the next cycle, and whether it runs
    logic [3:0]            slot;
    logic                  slot_run;
    logic                  connected;

    // out-of-range requests collapse to "no design"
    always_comb begin
        req_d = design_select;
        if ({1'b0, design_select} > NP) begin
            req_d = 4'd0;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        target_d = target_q;
        cnt_d    = '0;
        dto_d    = 1'b0;

        unique case (state_q)
            RUN: begin
                if (req_q != active_q) begin
                    target_d = req_q;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (!wbs_cyc_i || (active_q == 4'd0)) begin
                    state_d = ISOLATE;
                end else if (cnt_q == DRAIN_LAST) begin
                    state_d = ISOLATE;
                    dto_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISOLATE: begin
                active_d = target_q;
                if (target_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    state_d = RESET_HOLD;
                end
            end
            RESET_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // outputs are decoded from the next state so they register with it
    always_comb begin
        slot      = 4'd0;
        slot_run  = 1'b1;
        connected = 1'b0;

        unique case (1'b1)
            (state_d == RUN) || (state_d == DRAIN): begin
                slot      = active_d;
                connected = (active_d != 4'd0);
            end
            (state_d == RESET_HOLD): begin
                slot     = target_d;
                slot_run = 1'b0;
            end
            (state_d == RELEASE): begin
                slot = target_d;
            end
            default: begin
                slot = 4'd0;
            end
        endcase

        iso_d  = !connected;
        busy_d = (state_d != RUN);

        cs_d   = '1;
        nrst_d = '0;
        for (int i = 1; i <= NUM_PROJECTS; i++) begin
            if (slot == 4'(i)) begin
                cs_d[i]   = 1'b0;
                nrst_d[i] = slot_run;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            req_q    <= 4'd0;
            active_q <= 4'd0;
            target_q <= 4'd0;
            cnt_q    <= '0;
            cs_q     <= '1;
            nrst_q   <= '0;
            iso_q    <= 1'b1;
            busy_q   <= 1'b0;
            dto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            active_q <= active_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            cs_q     <= cs_d;
            nrst_q   <= nrst_d;
            iso_q    <= iso_d;
            busy_q   <= busy_d;
            dto_q    <= dto_d;
        end
    end

    assign active_select = active_q;
    assign designs_cs    = cs_q;
    assign designs_n_rst = nrst_q;
    assign isolate       = iso_q;
    assign switch_busy   = busy_q;
    assign drain_timeout = dto_q;

endmodule

// File: tb/tb_design_switch_sequencer.sv
// tb_design_switch_sequencer: directed and random handovers against a
// timeline model of each design switch.

module tb_design_switch_sequencer;

    localparam int NP = 13;
    localparam int RC = 8;
    localparam int DT = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    design_select;
    logic          wbs_cyc_i;
    logic [3:0]    active_select;
    logic [NP:1]   designs_cs;
    logic [NP:1]   designs_n_rst;
    logic          isolate;
    logic          switch_busy;
    logic          drain_timeout;

    int checks   = 0;
    int errors   = 0;
    int m_active = 0;

    always #5 clk = ~clk;

    design_switch_sequencer #(
        .NUM_PROJECTS (NP),
        .RST_CYCLES   (RC),
        .DRAIN_TIMEOUT(DT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .design_select(design_select),
        .wbs_cyc_i    (wbs_cyc_i),
        .active_select(active_select),
        .designs_cs   (designs_cs),
        .designs_n_rst(designs_n_rst),
        .isolate      (isolate),
        .switch_busy  (switch_busy),
        .drain_timeout(drain_timeout)
    );

    function automatic int map_sel(input int s);
        return (s >= 1 && s <= NP) ? s : 0;
    endfunction

    function automatic logic cyc_at(input int hi, input int e);
        return (hi > 0) && (e <= hi + 1);
    endfunction

    task automatic chk(input string tag, input int c,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @%0d: got %0h expected %0h", tag, c, got, exp);
        end
    endtask

    task automatic check_win(input string tag, input int c,
                             input int act, input int slot, input int non,
                             input int iso, input int busy, input int dto);
        logic [NP:1] ecs;
        logic [NP:1] enr;
        ecs = '1;
        enr = '0;
        for (int i = 1; i <= NP; i++) begin
            if (i == slot) begin
                ecs[i] = 1'b0;
                enr[i] = (non != 0);
            end
        end
        chk({tag, ".active"}, c, 32'(active_select), act);
        chk({tag, ".cs"}, c, 32'(designs_cs), 32'(ecs));
        chk({tag, ".n_rst"}, c, 32'(designs_n_rst), 32'(enr));
        chk({tag, ".isolate"}, c, 32'(isolate), iso);
        chk({tag, ".busy"}, c, 32'(switch_busy), busy);
        chk({tag, ".dto"}, c, 32'(drain_timeout), dto);
    endtask

    // Window c is the cycle after edge Ec, where E0 samples the request.
    // pre=1: the request was already sampled at the previous window's edge.
    task automatic handover(input int sel, input int hi, input bit pre,
                            input int late_sel, input int late_c);
        int a;
        int t;
        int nd;
        int last;
        int c;
        bit to;
        int e_act;
        int e_slot;
        int e_non;
        int e_iso;
        int e_busy;
        int e_dto;
        a = m_active;
        t = map_sel(sel);
        if (!pre) design_select = 4'(sel);
        if (t == a) begin
            wbs_cyc_i = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check_win("same", k, a, a, 1, (a == 0) ? 1 : 0, 0, 0);
            end
            return;
        end
        nd   = (a == 0) ? 1 : (((hi < DT) ? hi : DT) + 1);
        to   = (a != 0) && (hi > DT);
        last = (t == 0) ? nd + 2 : nd + 3 + RC;
        c    = pre ? 1 : 0;
        wbs_cyc_i = cyc_at(hi, c);
        while (c <= last) begin
            @(negedge clk);
            e_dto = 0;
            e_non = 1;
            if (c == 0) begin
                e_act = a; e_slot = a; e_iso = (a == 0); e_busy = 0;
            end else if (c <= nd) begin
                e_act = a; e_slot = a; e_iso = (a == 0); e_busy = 1;
            end else if (c == nd + 1) begin
                e_act = a; e_slot = 0; e_iso = 1; e_busy = 1;
                e_dto = to ? 1 : 0;
            end else if (t == 0) begin
                e_act = 0; e_slot = 0; e_iso = 1; e_busy = 0;
            end else if (c <= nd + 1 + RC) begin
                e_act = t; e_slot = t; e_iso = 1; e_busy = 1; e_non = 0;
            end else if (c == nd + 2 + RC) begin
                e_act = t; e_slot = t; e_iso = 1; e_busy = 1;
            end else begin
                e_act = t; e_slot = t; e_iso = 0; e_busy = 0;
            end
            check_win("hand", c, e_act, e_slot, e_non, e_iso, e_busy, e_dto);
            if (c == late_c) design_select = 4'(late_sel);
            wbs_cyc_i = cyc_at(hi, c + 1);
            c++;
        end
        wbs_cyc_i = 1'b0;
        m_active  = t;
    endtask

    initial begin
        int s;
        int h;
        int l;
        bit late;

        rst           = 1'b1;
        design_select = 4'd0;
        wbs_cyc_i     = 1'b0;
        repeat (2) @(negedge clk);
        check_win("reset", 0, 0, 0, 0, 1, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check_win("idle", 0, 0, 0, 0, 1, 0, 0);

        handover(3, 0, 1'b0, 0, -1);
        handover(5, 20, 1'b0, 0, -1);
        handover(2, 300, 1'b0, 0, -1);
        handover(0, 0, 1'b0, 0, -1);
        handover(15, 0, 1'b0, 0, -1);
        handover(4, 0, 1'b0, 7, 5);
        handover(7, 0, 1'b1, 0, -1);
        handover(7, 5, 1'b0, 0, -1);
        handover(14, 0, 1'b0, 0, -1);

        for (int k = 0; k < 24; k++) begin
            s    = $urandom_range(0, 15);
            h    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
            l    = $urandom_range(0, 15);
            late = ($urandom_range(0, 3) == 0) && (map_sel(s) != m_active);
            handover(s, h, 1'b0, l, late ? 2 : -1);
            if (late && map_sel(l) != m_active) begin
                handover(l, 0, 1'b1, 0, -1);
            end
        end

        handover(0, 0, 1'b0, 0, -1);
        design_select = 4'd6;
        wbs_cyc_i     = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 0) check_win("rh", c, 0, 0, 0, 1, 0, 0);
            else if (c <= 2) check_win("rh", c, 0, 0, 0, 1, 1, 0);
            else check_win("rh", c, 6, 6, 0, 1, 1, 0);
        end
        rst           = 1'b1;
        design_select = 4'd0;
        @(negedge clk);
        check_win("rst_mid", 7, 0, 0, 0, 1, 0, 0);
        rst = 1'b0;
        for (int c = 8; c < 11; c++) begin
            @(negedge clk);
            check_win("post_rst", c, 0, 0, 0, 1, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
